// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bundle of the write, read and issue signals between the
// decode/writeback pipeline stages and the reg_file_mp register file.
// The pipeline side uses the master modport, the register file the slave modport.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic                     WRITE;
    logic                     InstHIT;
    logic [ADDR_W-1:0]        INADDRESS;
    logic [DATA_W-1:0]        IN;
    logic [NUM_RD*ADDR_W-1:0] RDADDR;
    logic [NUM_RD*DATA_W-1:0] RDDATA;
    logic [NUM_RD-1:0]        RDBUSY;
    logic                     ISSUE;
    logic [ADDR_W-1:0]        ISSUEADDRESS;
    logic [DEPTH-1:0]         BUSYVEC;

    modport master (
        output WRITE, InstHIT, INADDRESS, IN, RDADDR, ISSUE, ISSUEADDRESS,
        input  RDDATA, RDBUSY, BUSYVEC
    );

    modport slave (
        input  WRITE, InstHIT, INADDRESS, IN, RDADDR, ISSUE, ISSUEADDRESS,
        output RDDATA, RDBUSY, BUSYVEC
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised pipeline register file with one write port,
// NUM_RD combinational read ports, an optional hardwired zero register and a
// per-register busy scoreboard used by decode to spot RAW hazards.
// Optional feature: define RF_BYPASS_EN to forward the writeback data to any
// read port addressing the register being written in the same cycle, and to
// mask that port's busy bit. Without it reads return the stored value and the
// raw scoreboard bit.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic          CLK,
    input logic          RESET,
    reg_file_mp_if.slave bus
);
    localparam int   DEPTH   = 2 ** ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    // Read port count outside the supported range stops elaboration.
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be within 1..4");
    end

    // One-hot decode of a register address into a scoreboard mask.
    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] addr);
        logic [DEPTH-1:0] vec;
        vec       = {DEPTH{1'b0}};
        vec[addr] = 1'b1;
        return vec;
    endfunction

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  clr_mask_s;
    logic [DEPTH-1:0]  set_mask_s;
    logic              wr_fire_s;
    logic              wr_store_s;
    logic              issue_set_s;

    // A writeback only counts when the instruction is valid; register 0
    // swallows writes and issues when it is hardwired.
    assign wr_fire_s   = bus.WRITE & bus.InstHIT;
    assign wr_store_s  = wr_fire_s & ~(ZERO_EN & (bus.INADDRESS == {ADDR_W{1'b0}}));
    assign issue_set_s = bus.ISSUE & ~(ZERO_EN & (bus.ISSUEADDRESS == {ADDR_W{1'b0}}));

    // Set is applied after clear so a new producer issued in the same cycle
    // as the old one retires keeps the register busy.
    assign clr_mask_s = wr_fire_s   ? onehot(bus.INADDRESS)    : {DEPTH{1'b0}};
    assign set_mask_s = issue_set_s ? onehot(bus.ISSUEADDRESS) : {DEPTH{1'b0}};

    // Next scoreboard state from retiring and newly issued producers.
    always_comb begin
        busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Register array and scoreboard; reset clears both at once and drops any write in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            busy_q <= busy_d;
            if (wr_store_s) begin
                regs_q[bus.INADDRESS] <= bus.IN;
            end
        end
    end

    assign bus.BUSYVEC = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              zero_s;
        logic              byp_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = bus.RDADDR[k*ADDR_W +: ADDR_W];
        assign zero_s = ZERO_EN & (addr_s == {ADDR_W{1'b0}});
`ifdef RF_BYPASS_EN
        // Forwarding is suppressed during reset so the ports read all-zero.
        assign byp_s  = RESET & wr_fire_s & (addr_s == bus.INADDRESS) & ~zero_s;
`else
        assign byp_s  = 1'b0;
`endif

        // Read mux: hardwired zero first, then forwarded writeback data, then storage.
        always_comb begin
            data_s = {DATA_W{1'b0}};
            busy_s = 1'b0;
            if (zero_s) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (byp_s) begin
                data_s = bus.IN;
                busy_s = 1'b0;
            end else begin
                data_s = regs_q[addr_s];
                busy_s = busy_q[addr_s];
            end
        end

        assign bus.RDDATA[k*DATA_W +: DATA_W] = data_s;
        assign bus.RDBUSY[k]                  = busy_s;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: two configurations of reg_file_mp (32-bit/32 regs/2 ports with
// hardwired zero, and 64-bit/16 regs/3 ports without) driven side by side and
// compared every cycle against an architectural model, plus directed checks
// with hand-computed values.
module tb_reg_file_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus per instance (index 0 = config A, 1 = config B).
    logic        wr    [2];
    logic        hit   [2];
    logic        iss   [2];
    logic [4:0]  waddr [2];
    logic [4:0]  iaddr [2];
    logic [63:0] wdata [2];
    logic [4:0]  ra    [2][3];

    // Model state: register contents and busy bits.
    logic [63:0] mem    [2][32];
    logic [31:0] busy_m [2];

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    reg_file_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) bus_b ();

    assign bus_a.WRITE        = wr[0];
    assign bus_a.InstHIT      = hit[0];
    assign bus_a.INADDRESS    = waddr[0];
    assign bus_a.IN           = wdata[0][31:0];
    assign bus_a.RDADDR       = {ra[0][1], ra[0][0]};
    assign bus_a.ISSUE        = iss[0];
    assign bus_a.ISSUEADDRESS = iaddr[0];

    assign bus_b.WRITE        = wr[1];
    assign bus_b.InstHIT      = hit[1];
    assign bus_b.INADDRESS    = waddr[1][3:0];
    assign bus_b.IN           = wdata[1];
    assign bus_b.RDADDR       = {ra[1][2][3:0], ra[1][1][3:0], ra[1][0][3:0]};
    assign bus_b.ISSUE        = iss[1];
    assign bus_b.ISSUEADDRESS = iaddr[1][3:0];

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .CLK(clk), .RESET(rst_n), .bus(bus_a)
    );
    reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .CLK(clk), .RESET(rst_n), .bus(bus_b)
    );

    function automatic bit zr(int i);
        return (i == 0);
    endfunction

    function automatic int nrd(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] dmask(int i);
        return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] dut_rd(int i, int k);
        if (i == 0) return {32'h0, bus_a.RDDATA[k*32 +: 32]};
        return bus_b.RDDATA[k*64 +: 64];
    endfunction

    function automatic logic dut_busy(int i, int k);
        if (i == 0) return bus_a.RDBUSY[k];
        return bus_b.RDBUSY[k];
    endfunction

    function automatic logic [31:0] dut_bv(int i);
        if (i == 0) return bus_a.BUSYVEC;
        return {16'h0, bus_b.BUSYVEC};
    endfunction

    // Architectural rule: same-cycle forwarding of a valid write to a matching, non-zero-register read.
    function automatic bit model_bypass(int i, logic [4:0] a);
`ifdef RF_BYPASS_EN
        return rst_n && wr[i] && hit[i] && (a == waddr[i]) && !(zr(i) && a == 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] exp_rd(int i, int k);
        logic [4:0] a;
        a = ra[i][k];
        if (!rst_n) return 64'h0;
        if (zr(i) && a == 5'd0) return 64'h0;
        if (model_bypass(i, a)) return wdata[i] & dmask(i);
        return mem[i][a];
    endfunction

    function automatic logic exp_busy(int i, int k);
        logic [4:0] a;
        a = ra[i][k];
        if (!rst_n) return 1'b0;
        if (model_bypass(i, a)) return 1'b0;
        return busy_m[i][a];
    endfunction

    // Scoreboard rule: retire clears, issue sets, and issue wins on the same register.
    function automatic logic [31:0] next_busy(int i);
        logic [31:0] b;
        b = busy_m[i];
        if (wr[i] && hit[i]) b[waddr[i]] = 1'b0;
        if (iss[i] && !(zr(i) && iaddr[i] == 5'd0)) b[iaddr[i]] = 1'b1;
        return b;
    endfunction

    // Model update: cleared asynchronously by reset, otherwise follows writes and issues at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                busy_m[i] <= 32'h0;
                for (int r = 0; r < 32; r++) mem[i][r] <= 64'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr[i] && hit[i] && !(zr(i) && waddr[i] == 5'd0))
                    mem[i][waddr[i]] <= wdata[i] & dmask(i);
                busy_m[i] <= next_busy(i);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busyvec%0d", i), {32'h0, dut_bv(i)}, {32'h0, busy_m[i]});
            for (int k = 0; k < nrd(i); k++) begin
                chk($sformatf("rddata%0d_%0d", i, k), dut_rd(i, k), exp_rd(i, k));
                chk($sformatf("rdbusy%0d_%0d", i, k), {63'h0, dut_busy(i, k)}, {63'h0, exp_busy(i, k)});
            end
        end
    end

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            wr[i] = 1'b0; hit[i] = 1'b0; iss[i] = 1'b0;
            waddr[i] = 5'd0; iaddr[i] = 5'd0; wdata[i] = 64'h0;
            for (int k = 0; k < 3; k++) ra[i][k] = 5'd0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [63:0] d);
        wr[0] = 1'b1; hit[0] = 1'b1; waddr[0] = a; wdata[0] = d;
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [63:0] d);
        wr[1] = 1'b1; hit[1] = 1'b1; waddr[1] = a; wdata[1] = d;
    endtask

    initial begin
        logic [4:0] am;
        idle();
        #1 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        #2;
        chk("rst_bv", {32'h0, dut_bv(0)}, 64'h0);
        chk("rst_rd", dut_rd(0, 0), 64'h0);

        // Two consecutive writes, read back on both ports.
        wr_a(5'd1, 64'd28);
        step(); wr_a(5'd6, 64'd108);
        step(); idle(); ra[0][0] = 5'd1; ra[0][1] = 5'd6;
        #2;
        chk("wr_r1", dut_rd(0, 0), 64'd28);
        chk("wr_r6", dut_rd(0, 1), 64'd108);

        // Write without a valid instruction must not land.
        wr_a(5'd4, 64'd6); hit[0] = 1'b0;
        step(); idle(); ra[0][0] = 5'd4;
        #2 chk("nohit_r4", dut_rd(0, 0), 64'd0);

        // Hardwired zero register ignores writes and issues.
        wr_a(5'd0, 64'hFFFF_FFFF); iss[0] = 1'b1; iaddr[0] = 5'd0;
        #2 chk("zero_byp", dut_rd(0, 0), 64'd0);
        step(); idle();
        #2;
        chk("zero_rd", dut_rd(0, 0), 64'd0);
        chk("zero_bv", {63'h0, dut_bv(0)[0]}, 64'd0);

        // Reg 3 = 15 issued busy in the same cycle, then forwarding of 50.
        wr_a(5'd3, 64'd15); iss[0] = 1'b1; iaddr[0] = 5'd3;
        step(); idle(); wr_a(5'd3, 64'd50); ra[0][0] = 5'd3;
        #2;
`ifdef RF_BYPASS_EN
        chk("byp_rd", dut_rd(0, 0), 64'd50);
        chk("byp_busy", {63'h0, dut_busy(0, 0)}, 64'd0);
`else
        chk("nobyp_rd", dut_rd(0, 0), 64'd15);
        chk("nobyp_busy", {63'h0, dut_busy(0, 0)}, 64'd1);
`endif
        step(); idle(); ra[0][0] = 5'd3;
        #2;
        chk("byp_after", dut_rd(0, 0), 64'd50);
        chk("byp_bv3", {63'h0, dut_bv(0)[3]}, 64'd0);

        // Issue reg 5 at edge n, retire it at edge n+3.
        iss[0] = 1'b1; iaddr[0] = 5'd5;
        step(); idle(); ra[0][0] = 5'd5; ra[0][1] = 5'd7;
        #2;
        chk("sb_bv5", {63'h0, dut_bv(0)[5]}, 64'd1);
        chk("sb_rdbusy", {63'h0, dut_busy(0, 0)}, 64'd1);
        step(); step(); wr_a(5'd5, 64'd77);
        #2 chk("sb_hold", {63'h0, dut_bv(0)[5]}, 64'd1);
        step(); wr[0] = 1'b0; hit[0] = 1'b0;
        #2 chk("sb_clr", {63'h0, dut_bv(0)[5]}, 64'd0);

        // Issue and retire of reg 5 together: stays busy, data still written.
        wr_a(5'd5, 64'd99); iss[0] = 1'b1; iaddr[0] = 5'd5;
        step(); idle(); ra[0][0] = 5'd5;
        #2;
        chk("sb_same_bv", {63'h0, dut_bv(0)[5]}, 64'd1);
        chk("sb_same_rd", dut_rd(0, 0), 64'd99);

        // Wide configuration: three independent ports, register 0 is ordinary.
        wr_b(5'd2, 64'hDEAD_BEEF_0000_0001);
        step(); wr_b(5'd9, 64'hDEAD_BEEF_0000_0002);
        step(); wr_b(5'd15, 64'hDEAD_BEEF_0000_0003);
        step(); wr_b(5'd0, 64'h55);
        step(); idle(); ra[1][0] = 5'd2; ra[1][1] = 5'd9; ra[1][2] = 5'd15;
        #2;
        chk("b_p0", dut_rd(1, 0), 64'hDEAD_BEEF_0000_0001);
        chk("b_p1", dut_rd(1, 1), 64'hDEAD_BEEF_0000_0002);
        chk("b_p2", dut_rd(1, 2), 64'hDEAD_BEEF_0000_0003);
        ra[1][0] = 5'd0;
        #1 chk("b_r0", dut_rd(1, 0), 64'h55);

        // Reset between edges during a write to reg 2.
        step(); idle(); ra[0][0] = 5'd1; wr_a(5'd2, 64'd95);
        #2 chk("pre_rst_rd", dut_rd(0, 0), 64'd28);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", dut_rd(0, 0), 64'd0);
        chk("mid_rst_bv", {32'h0, dut_bv(0)}, 64'd0);
        step(); step(); idle();
        rst_n = 1'b1;
        step(); ra[0][0] = 5'd2;
        #2 chk("rst_cancel_r2", dut_rd(0, 0), 64'd0);

        // Randomised traffic with address bias to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 2; i++) begin
                am       = (i == 0) ? 5'h1F : 5'h0F;
                if ($urandom_range(0, 1) == 1) am = am & 5'h07;
                wr[i]    = 1'($urandom_range(0, 1));
                hit[i]   = ($urandom_range(0, 4) != 0);
                waddr[i] = 5'($urandom) & am;
                wdata[i] = {$urandom, $urandom} & dmask(i);
                iss[i]   = ($urandom_range(0, 2) == 0);
                iaddr[i] = 5'($urandom) & am;
                for (int k = 0; k < 3; k++)
                    ra[i][k] = ($urandom_range(0, 2) == 0) ? waddr[i] : (5'($urandom) & am);
            end
        end
        step(); idle(); rst_n = 1'b1;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
